// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and
// the even-parity helper used by both the transmit and receive paths.
package uart_pkg;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_OSR       = 16;
    localparam int MAX_DATA_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rxState_t;

    // Callers zero-extend narrower payloads; zeros do not change the XOR.
    function automatic logic calcParity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_parity_checker_if.sv
// Receive-result bus from the UART receiver to the receive holding logic.
interface uart_rx_parity_checker_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);

    logic [DATA_BITS-1:0] RX_DATA;
    logic                 rx_valid;
    logic                 PARITY_ERR;
    logic                 FRAME_ERR;
    logic                 rx_busy;

    modport master (
        output RX_DATA,
        output rx_valid,
        output PARITY_ERR,
        output FRAME_ERR,
        output rx_busy
    );

    modport slave (
        input RX_DATA,
        input rx_valid,
        input PARITY_ERR,
        input FRAME_ERR,
        input rx_busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous pins that idle high (RX, CTS).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_parity_checker.sv
// UART receiver: deserialises one 8N1/8E1 frame, checks even parity and the
// stop bit, and reports the byte with a one-clock valid pulse.
module uart_rx_parity_checker
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int PARITY_EN = 1,
    parameter int OSR       = DEF_OSR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_tick,
    input  logic                      RX_IN,
    uart_rx_parity_checker_if.master  rx_if
);

    localparam int TW = $clog2(OSR);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                     w_rxS;
    logic [MAX_DATA_BITS-1:0] w_parData;
    logic                     w_parMismatch;

    rxState_t                 r_state;
    logic [TW-1:0]            r_tickCnt;
    logic [BW-1:0]            r_bitCnt;
    logic [DATA_BITS-1:0]     r_shift;
    logic                     r_parRx;
    logic [DATA_BITS-1:0]     r_rxData;
    logic                     r_valid;
    logic                     r_parErr;
    logic                     r_frameErr;
    logic                     r_busy;
    logic [1:0]               r_warm;
    logic                     r_lineSeen;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (RX_IN),
        .o_sync  (w_rxS)
    );

    always_comb begin
        w_parData                  = '0;
        w_parData[DATA_BITS-1:0]   = r_shift;
    end

    assign w_parMismatch = calcParity(w_parData) ^ r_parRx;

    // r_warm waits out the synchroniser refill after reset; until the line has
    // been seen high, a low line is treated as a break, not a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tickCnt  <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_parRx    <= 1'b0;
            r_rxData   <= '0;
            r_valid    <= 1'b0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
            r_busy     <= 1'b0;
            r_warm     <= 2'b00;
            r_lineSeen <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_warm  <= {r_warm[0], 1'b1};
            if (sample_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_warm[1]) begin
                            if (w_rxS) begin
                                r_lineSeen <= 1'b1;
                            end else if (r_lineSeen) begin
                                r_state   <= ST_START;
                                r_tickCnt <= '0;
                                r_busy    <= 1'b1;
                            end else begin
                                r_state <= ST_BREAK;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    ST_START: begin
                        if (r_tickCnt == TICK_MID) begin
                            r_tickCnt <= '0;
                            if (w_rxS) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state  <= ST_DATA;
                                r_bitCnt <= '0;
                            end
                        end else begin
                            r_tickCnt <= r_tickCnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_tickCnt == TICK_LAST) begin
                            r_tickCnt         <= '0;
                            r_shift[r_bitCnt] <= w_rxS;
                            if (r_bitCnt == BIT_LAST) begin
                                r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bitCnt <= r_bitCnt + 1'b1;
                            end
                        end else begin
                            r_tickCnt <= r_tickCnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (r_tickCnt == TICK_LAST) begin
                            r_tickCnt <= '0;
                            r_parRx   <= w_rxS;
                            r_state   <= ST_STOP;
                        end else begin
                            r_tickCnt <= r_tickCnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (r_tickCnt == TICK_LAST) begin
                            r_tickCnt  <= '0;
                            r_rxData   <= r_shift;
                            r_valid    <= 1'b1;
                            r_parErr   <= (PARITY_EN != 0) && w_parMismatch;
                            r_frameErr <= ~w_rxS;
                            if (w_rxS) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ST_BREAK;
                            end
                        end else begin
                            r_tickCnt <= r_tickCnt + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (w_rxS) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_lineSeen <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_if.RX_DATA    = r_rxData;
    assign rx_if.rx_valid   = r_valid;
    assign rx_if.PARITY_ERR = r_parErr;
    assign rx_if.FRAME_ERR  = r_frameErr;
    assign rx_if.rx_busy    = r_busy;

endmodule
